i2s_rx: RTL and testbench

- I2S slave receiver: the inbound counterpart of the core's I2S transmitter.
- Recovers stereo PCM from an external I2S source (codec ADC, digital line-in on the AUDIO_IN path) and presents parallel left/right samples plus a strobe to clk_sys logic.
- sclk/lrclk/sdata are asynchronous to clk_sys; they are oversampled, not used as clocks.
- Philips I2S format: MSB-first, MSB one sclk after the lrclk transition, lrclk=0 is left.

---
 rtl/i2s_rx.sv | 174 +++++++++++++++++
 tb/tb_i2s_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S slave receiver, pins oversampled on clk_sys.
// Ports: clk_sys, reset_n (async low), enable, sclk/lrclk/sdata (async),
//   err_clr; left_chan/right_chan, sample_valid, locked, frame_err.
// Option: define I2S_RX_MONO_MIX_EN to deliver (L+R)>>>1 on both channels.
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int MAX_SLOT     = 32,
  parameter int TIMEOUT_BITS = 10
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sclk,
  input  logic                    lrclk,
  input  logic                    sdata,
  input  logic                    err_clr,
  output logic [SAMPLE_WIDTH-1:0] left_chan,
  output logic [SAMPLE_WIDTH-1:0] right_chan,
  output logic                    sample_valid,
  output logic                    locked,
  output logic                    frame_err
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int CW = $clog2(MAX_SLOT + 1);

  typedef enum logic [1:0] {
    SEEK,
    RX_L,
    RX_R
  } state_t;

  state_t state, state_nxt;

  // [0],[1] synchronizer, [2] history for edge detect
  logic [2:0] sclk_q;
  logic [1:0] lr_q;
  logic [1:0] sd_q;
  logic       lr_prev;

  logic [CW-1:0]           bit_cnt;
  logic [SW-1:0]           shreg;
  logic [SW-1:0]           left_hold;
  logic [SW-1:0]           word;
  logic [SW-1:0]           bit_mask;
  logic [SW-1:0]           out_l;
  logic [SW-1:0]           out_r;
  logic [TIMEOUT_BITS-1:0] wd;

  logic rise, trans, len_ok, timeout;
  logic set_err, load_left, load_out;

  assign rise    = sclk_q[1] & ~sclk_q[2];
  assign trans   = rise & (lr_q[1] != lr_prev);
  assign timeout = &wd;

  // Mask shifts out of range past SAMPLE_WIDTH, dropping extra bits
  assign bit_mask = {1'b1, {(SW-1){1'b0}}} >> bit_cnt;
  assign word     = sd_q[1] ? (shreg | bit_mask) : shreg;

  // Slot length is bit_cnt+1; saturation at MAX_SLOT means too long
  assign len_ok = (bit_cnt >= CW'(SW - 1)) &&
                  (bit_cnt != CW'(MAX_SLOT));

`ifdef I2S_RX_MONO_MIX_EN
  logic [SW:0] mix_sum;
  assign mix_sum = {left_hold[SW-1], left_hold} + {word[SW-1], word};
  assign out_l   = mix_sum[SW:1];
  assign out_r   = mix_sum[SW:1];
`else
  assign out_l = left_hold;
  assign out_r = word;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= SEEK;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    load_left = 1'b0;
    load_out  = 1'b0;
    if (!enable) begin
      state_nxt = SEEK;
    end else begin
      unique case (state)
        SEEK: begin
          if (trans && !lr_q[1]) state_nxt = RX_L;
        end
        RX_L: begin
          if (timeout) begin
            set_err   = 1'b1;
            state_nxt = SEEK;
          end else if (trans && lr_q[1]) begin
            if (len_ok) begin
              load_left = 1'b1;
              state_nxt = RX_R;
            end else begin
              set_err   = 1'b1;
              state_nxt = SEEK;
            end
          end
        end
        RX_R: begin
          if (timeout) begin
            set_err   = 1'b1;
            state_nxt = SEEK;
          end else if (trans && !lr_q[1]) begin
            if (len_ok) begin
              load_out  = 1'b1;
              state_nxt = RX_L;
            end else begin
              set_err   = 1'b1;
              state_nxt = SEEK;
            end
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q       <= '0;
      lr_q         <= '0;
      sd_q         <= '0;
      lr_prev      <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      wd           <= '0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      lr_q   <= {lr_q[0], lrclk};
      sd_q   <= {sd_q[0], sdata};

      if (rise) lr_prev <= lr_q[1];

      if (!enable || trans) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (rise) begin
        shreg <= word;
        if (bit_cnt != CW'(MAX_SLOT)) bit_cnt <= bit_cnt + 1'b1;
      end

      if (!enable || state == SEEK || rise) wd <= '0;
      else                                  wd <= wd + 1'b1;

      if (!enable)        left_hold <= '0;
      else if (load_left) left_hold <= word;

      if (load_out) begin
        left_chan  <= out_l;
        right_chan <= out_r;
      end

      sample_valid <= load_out;
      locked       <= (state_nxt != SEEK);

      if (set_err)      frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed/random I2S frames into i2s_rx,
// checked against a sample-level reference model.
module tb_i2s_rx;

  localparam int SW   = 16;
  localparam int HALF = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable  = 1'b0;
  logic          sclk    = 1'b1;
  logic          lrclk   = 1'b1;
  logic          sdata   = 1'b0;
  logic          err_clr = 1'b0;
  logic [SW-1:0] left_chan;
  logic [SW-1:0] right_chan;
  logic          sample_valid;
  logic          locked;
  logic          frame_err;

  int vectors     = 0;
  int miscompares = 0;

  logic          pend = 1'b0;
  logic [SW-1:0] got_l[$];
  logic [SW-1:0] got_r[$];
  logic [SW-1:0] exp_l[$];
  logic [SW-1:0] exp_r[$];
  logic [SW-1:0] last_l = '0;
  logic [SW-1:0] last_r = '0;

  i2s_rx dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .enable       (enable),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .err_clr      (err_clr),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (sample_valid) begin
      got_l.push_back(left_chan);
      got_r.push_back(right_chan);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Reference: what a stereo pair should look like on the outputs
  task automatic model_push(input logic [SW-1:0] l,
                            input logic [SW-1:0] r);
`ifdef I2S_RX_MONO_MIX_EN
    int s;
    s = (int'($signed(l)) + int'($signed(r))) >>> 1;
    exp_l.push_back(s[SW-1:0]);
    exp_r.push_back(s[SW-1:0]);
`else
    exp_l.push_back(l);
    exp_r.push_back(r);
`endif
  endtask

  // One sclk period; data lags lrclk by one bit (Philips format)
  task automatic bit_out(input logic lr, input logic d);
    @(negedge clk_sys);
    sclk  = 1'b0;
    lrclk = lr;
    sdata = pend;
    pend  = d;
    repeat (HALF - 1) @(negedge clk_sys);
    sclk = 1'b1;
    repeat (HALF) @(negedge clk_sys);
  endtask

  task automatic slot(input logic lr, input int len,
                      input logic [31:0] w);
    for (int i = 0; i < len; i++)
      bit_out(lr, (i < 32) ? w[31-i] : 1'b0);
  endtask

  task automatic frame(input logic [SW-1:0] l,
                       input logic [SW-1:0] r,
                       input int len);
    slot(1'b0, len, {l, 16'($urandom)});
    slot(1'b1, len, {r, 16'($urandom)});
    model_push(l, r);
  endtask

  task automatic check_pairs(input int n);
    repeat (20) @(negedge clk_sys);
    chk("pair_count", got_l.size(), n);
    for (int i = 0; i < got_l.size() && i < exp_l.size(); i++) begin
      chk("left_pair", got_l[i], exp_l[i]);
      chk("right_pair", got_r[i], exp_r[i]);
    end
    while (got_l.size() > 0) begin
      void'(got_l.pop_front());
      void'(got_r.pop_front());
      if (exp_l.size() > 0) begin
        last_l = exp_l.pop_front();
        last_r = exp_r.pop_front();
      end
    end
  endtask

  task automatic clear_err();
    @(negedge clk_sys);
    err_clr = 1'b1;
    @(negedge clk_sys);
    err_clr = 1'b0;
    @(negedge clk_sys);
    chk("err_clr", frame_err, 1'b0);
  endtask

  initial begin
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_left", left_chan, '0);
    chk("rst_right", right_chan, '0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_err", frame_err, 1'b0);

    // 64-fs frames, 32-bit slots
    enable = 1'b1;
    slot(1'b1, 32, $urandom);
    frame(16'h1234, 16'hABCD, 32);
    for (int i = 0; i < 3; i++)
      frame(16'($urandom), 16'($urandom), 32);
    check_pairs(3);
    chk("a_locked", locked, 1'b1);
    chk("a_err", frame_err, 1'b0);

    // 32-fs frames, exactly SAMPLE_WIDTH bits per slot
    frame(16'h8001, 16'h7FFE, 16);
    frame(16'h7FFF, 16'h7FFF, 16);
    frame(16'h8000, 16'h0000, 16);
    frame(16'($urandom), 16'($urandom), 16);
    check_pairs(4);
    chk("b_err", frame_err, 1'b0);

    // short left slot
    slot(1'b0, 12, $urandom);
    slot(1'b1, 16, $urandom);
    chk("c_err", frame_err, 1'b1);
    chk("c_locked", locked, 1'b0);
    frame(16'($urandom), 16'($urandom), 16);
    frame(16'($urandom), 16'($urandom), 16);
    check_pairs(2);
    chk("c_sticky", frame_err, 1'b1);
    clear_err();

    // sclk stall mid-slot
    slot(1'b0, 10, $urandom);
    repeat (1100) @(negedge clk_sys);
    chk("d_err", frame_err, 1'b1);
    chk("d_locked", locked, 1'b0);
    check_pairs(1);
    chk("d_hold_l", left_chan, last_l);
    chk("d_hold_r", right_chan, last_r);
    slot(1'b1, 16, $urandom);
    clear_err();

    // enable dropped mid right slot
    frame(16'($urandom), 16'($urandom), 16);
    slot(1'b0, 16, $urandom);
    slot(1'b1, 8, $urandom);
    enable = 1'b0;
    repeat (10) @(negedge clk_sys);
    chk("e_locked", locked, 1'b0);
    enable = 1'b1;
    slot(1'b1, 8, $urandom);
    frame(16'($urandom), 16'($urandom), 16);
    frame(16'($urandom), 16'($urandom), 16);
    check_pairs(2);
    slot(1'b0, 16, $urandom);
    check_pairs(1);
    chk("e_locked2", locked, 1'b1);
    chk("e_err", frame_err, 1'b0);
    chk("e_out_l", left_chan, last_l);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
